// File: rtl/cache_axi_bridge.sv
// Cache-to-AXI bridge for a 32-bit slave.
// The read channel and the write channel each run their own FSM and allow at
// most one outstanding INCR burst each. A read to a line with a pending write
// is held off until that write has completed.
module cache_axi_bridge (
    input  logic         clk_g,
    input  logic         resetn,
    // cache read port
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    // cache write port
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    // AXI read address / data
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic         arvalid,
    input  logic         arready,
    input  logic [31:0]  rdata,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    // AXI write address / data / response
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic         bvalid,
    output logic         bready
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wstate_t;

    rstate_t        r_state_q, r_state_d;
    wstate_t        w_state_q, w_state_d;

    logic [31:0]    araddr_q;
    logic [7:0]     arlen_q;
    logic [31:0]    awaddr_q;
    logic [7:0]     awlen_q;
    logic [3:0]     wstrb_q;
    logic [127:0]   wbuf_q;
    logic [1:0]     beat_q;

    logic           rd_line;
    logic           wr_line;
    logic           conflict;

    assign rd_line  = (rd_type == 3'b100);
    assign wr_line  = (wr_type == 3'b100);
    assign conflict = (w_state_q != W_IDLE) && (rd_addr[31:4] == awaddr_q[31:4]);

    assign araddr = araddr_q;
    assign arlen  = arlen_q;
    assign awaddr = awaddr_q;
    assign awlen  = awlen_q;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------

    // Read FSM state register.
    always_ff @(posedge clk_g) begin
        if (!resetn) r_state_q <= R_IDLE;
        else         r_state_q <= r_state_d;
    end

    // Read FSM next-state logic.
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE: if (rd_req && rd_rdy)   r_state_d = R_AR;
            R_AR:   if (arready)            r_state_d = R_DATA;
            R_DATA: if (rvalid && rlast)    r_state_d = R_IDLE;
            default:                        r_state_d = R_IDLE;
        endcase
    end

    // Read FSM outputs; handshakes are forced low while reset is held so
    // an abandoned burst reports nothing even before the state clears.
    always_comb begin
        rd_rdy    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        ret_data  = '0;
        if (resetn) begin
            case (r_state_q)
                R_IDLE: rd_rdy  = !conflict;
                R_AR:   arvalid = 1'b1;
                R_DATA: begin
                    rready    = 1'b1;
                    ret_valid = rvalid;
                    ret_last  = rlast;
                    ret_data  = rdata;
                end
                default: ;
            endcase
        end
    end

    // Latch the read burst address and length on accept.
    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            araddr_q <= '0;
            arlen_q  <= '0;
        end else if (rd_req && rd_rdy) begin
            araddr_q <= rd_line ? {rd_addr[31:4], 4'h0} : rd_addr;
            arlen_q  <= rd_line ? 8'd3 : 8'd0;
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------

    // Write FSM state register.
    always_ff @(posedge clk_g) begin
        if (!resetn) w_state_q <= W_IDLE;
        else         w_state_q <= w_state_d;
    end

    // Write FSM next-state logic.
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE: if (wr_req && wr_rdy)           w_state_d = W_AW;
            W_AW:   if (awready)                    w_state_d = W_DATA;
            W_DATA: if (wvalid && wready && wlast)  w_state_d = W_RESP;
            W_RESP: if (bvalid)                     w_state_d = W_IDLE;
            default:                                w_state_d = W_IDLE;
        endcase
    end

    // Write FSM outputs; the current beat is selected from the line buffer.
    always_comb begin
        wr_rdy  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wlast   = 1'b0;
        bready  = 1'b0;
        wdata   = wbuf_q[{beat_q, 5'd0} +: 32];
        wstrb   = wstrb_q;
        if (resetn) begin
            case (w_state_q)
                W_IDLE: wr_rdy  = 1'b1;
                W_AW:   awvalid = 1'b1;
                W_DATA: begin
                    wvalid = 1'b1;
                    wlast  = (beat_q == awlen_q[1:0]);
                end
                W_RESP: bready  = 1'b1;
                default: ;
            endcase
        end
    end

    // Buffer the write request on accept and step the beat counter.
    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            awaddr_q <= '0;
            awlen_q  <= '0;
            wstrb_q  <= '0;
            wbuf_q   <= '0;
            beat_q   <= '0;
        end else if (wr_req && wr_rdy) begin
            awaddr_q <= wr_line ? {wr_addr[31:4], 4'h0} : wr_addr;
            awlen_q  <= wr_line ? 8'd3 : 8'd0;
            wstrb_q  <= wr_line ? 4'hF : wr_wstrb;
            wbuf_q   <= wr_data;
            beat_q   <= '0;
        end else if (w_state_q == W_AW && awready) begin
            beat_q   <= '0;
        end else if (wvalid && wready) begin
            beat_q   <= beat_q + 2'd1;
        end
    end

endmodule

// File: doc/cache_axi_bridge.md
CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

Interface
REQ-001 The module SHALL have the port clk_g, input, 1 bit: clock; all logic on its rising edge.
REQ-002 The module SHALL have the port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-003 The module SHALL have the port rd_req, input, 1 bit: cache read request.
REQ-004 The module SHALL have the port rd_type, input, 3 bits: 3'b100 = 4-word line; any other value = single word.
REQ-005 The module SHALL have the port rd_addr, input, 32 bits: read byte address.
REQ-006 The module SHALL have the port rd_rdy, output, 1 bit: read request accepted when rd_req && rd_rdy.
REQ-007 The module SHALL have the port ret_valid, output, 1 bit: a read beat is valid.
REQ-008 The module SHALL have the port ret_last, output, 1 bit: final read beat.
REQ-009 The module SHALL have the port ret_data, output, 32 bits: read beat data.
REQ-010 The module SHALL have the port wr_req, input, 1 bit: cache write request (victim writeback or uncached store).
REQ-011 The module SHALL have the port wr_type, input, 3 bits: 3'b100 = 4-word line; any other value = single word.
REQ-012 The module SHALL have the port wr_addr, input, 32 bits: write byte address.
REQ-013 The module SHALL have the port wr_wstrb, input, 4 bits: byte strobe for single-word writes.
REQ-014 The module SHALL have the port wr_data, input, 128 bits: write data; word i is bits [32i+31:32i].
REQ-015 The module SHALL have the port wr_rdy, output, 1 bit: write request accepted when wr_req && wr_rdy.
REQ-016 The module SHALL have the port araddr, output, 32 bits: AXI read address.
REQ-017 The module SHALL have the port arlen, output, 8 bits: AXI read burst length minus 1.
REQ-018 The module SHALL have the port arvalid, output, 1 bit: AXI read address valid.
REQ-019 The module SHALL have the port arready, input, 1 bit: AXI read address ready.
REQ-020 The module SHALL have the port rdata, input, 32 bits: AXI read data.
REQ-021 The module SHALL have the port rlast, input, 1 bit: AXI last read beat.
REQ-022 The module SHALL have the port rvalid, input, 1 bit: AXI read data valid.
REQ-023 The module SHALL have the port rready, output, 1 bit: AXI read data ready.
REQ-024 The module SHALL have the port awaddr, output, 32 bits: AXI write address.
REQ-025 The module SHALL have the port awlen, output, 8 bits: AXI write burst length minus 1.
REQ-026 The module SHALL have the port awvalid, output, 1 bit: AXI write address valid.
REQ-027 The module SHALL have the port awready, input, 1 bit: AXI write address ready.
REQ-028 The module SHALL have the port wdata, output, 32 bits: AXI write data.
REQ-029 The module SHALL have the port wstrb, output, 4 bits: AXI write strobe.
REQ-030 The module SHALL have the port wlast, output, 1 bit: AXI last write beat.
REQ-031 The module SHALL have the port wvalid, output, 1 bit: AXI write data valid.
REQ-032 The module SHALL have the port wready, input, 1 bit: AXI write data ready.
REQ-033 The module SHALL have the port bvalid, input, 1 bit: AXI write response valid.
REQ-034 The module SHALL have the port bready, output, 1 bit: AXI write response ready.

Function
REQ-035 The slave is 32-bit, all bursts are INCR, and the read and write channels SHALL run independently, with at most one outstanding transaction each.
REQ-036 The read FSM SHALL have states R_IDLE, R_AR and R_DATA; rd_rdy = (R_IDLE && !conflict); on accept, araddr, arlen and the line address are latched and the FSM moves to R_AR.
REQ-037 The read address SHALL be araddr = {rd_addr[31:4],4'h0} with arlen = 3 when rd_type = 3'b100; otherwise araddr = rd_addr with arlen = 0.
REQ-038 In R_AR, arvalid SHALL be 1 and held, with araddr stable, until arready; then the FSM moves to R_DATA.
REQ-039 In R_DATA, rready SHALL be 1 and ret_valid = rvalid, ret_data = rdata, ret_last = rlast, combinationally with zero latency; on rvalid && rlast the FSM returns to R_IDLE.
REQ-040 The write FSM SHALL have states W_IDLE, W_AW, W_DATA and W_RESP; wr_rdy = W_IDLE; on accept, wr_data, address, length and strobe are buffered.
REQ-041 The write address SHALL follow the same alignment and length rule as REQ-037, applied to wr_addr and wr_type.
REQ-042 In W_AW, awvalid SHALL be 1 until awready; then the FSM moves to W_DATA with the beat counter at 0.
REQ-043 In W_DATA, wvalid SHALL be 1 and wdata = buf[beat*32 +: 32]; wstrb = 4'hF for a line write, else the latched wr_wstrb.
REQ-044 wlast SHALL be 1 when beat == awlen[1:0]; each wvalid && wready advances beat; the last accepted beat moves the FSM to W_RESP.
REQ-045 In W_RESP, bready SHALL be 1; bvalid returns the FSM to W_IDLE, and wr_rdy is 1 in the following cycle.
REQ-046 conflict SHALL be (write FSM not W_IDLE) && rd_addr[31:4] == buffered write line address, where the buffered line address is the latched write address [31:4]; a read never passes a pending write to the same line.
REQ-047 Same-cycle rd_req and wr_req with no conflict SHALL both be accepted.
REQ-048 Read and write beats SHALL be emitted in ascending word order.

Reset
REQ-049 While resetn = 0, both FSMs SHALL go to IDLE and arvalid, rready, ret_valid, ret_last, awvalid, wvalid, wlast and bready SHALL be 0; rd_rdy and wr_rdy SHALL be 1 from the first cycle after reset; a reset mid-transfer abandons the transfer and reports no further beats.

Verification
REQ-050 The bench SHALL drive rd_type 3'b100 with rd_addr 0x1C0002A4 -> araddr 0x1C0002A0 and arlen 3; beats 0x11, 0x22, 0x33, 0x44 with rvalid gaps -> four ret_valid pulses, ret_last only with 0x44.
REQ-051 The bench SHALL drive rd_type 3'b010 with rd_addr 0x10000008 -> araddr 0x10000008, arlen 0, a single beat with ret_last = 1.
REQ-052 The bench SHALL drive a line write to 0x80000040 with words 0xA0, 0xA1, 0xA2, 0xA3 and random wready -> awlen 3 and wdata in order A0..A3 with wstrb 0xF; wlast only on A3; wr_rdy = 0 until the cycle after bvalid.
REQ-053 The bench SHALL drive a single write with wr_wstrb 4'b0011 to 0x80000004 -> awlen 0, wdata = word 0, wstrb 0x3, wlast = 1.
REQ-054 With a write pending to 0x80000040, the bench SHALL show rd_addr 0x80000048 -> rd_rdy = 0 until W_IDLE, and rd_addr 0x80000080 -> accepted in the same cycle.
REQ-055 The bench SHALL assert resetn = 0 after 2 read beats -> rready = 0 and ret_valid = 0 during reset, and rd_rdy = 1 after release.
